// File: rtl/switch_sched.sv
// Output scheduler for the 4-port switch: per-output round-robin grants,
// multicast progress tracking per input head, FIFO pop strobes and statistics.
module switch_sched #(
   parameter int NUM_PORTS = 4,
   parameter int CNT_W     = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PORTS-1:0]           i_head_valid,
   input  logic [NUM_PORTS*NUM_PORTS-1:0] i_head_target,
   input  logic [NUM_PORTS-1:0]           i_out_ready,
   output logic [NUM_PORTS*NUM_PORTS-1:0] o_grant,
   output logic [NUM_PORTS-1:0]           o_out_valid,
   output logic [NUM_PORTS-1:0]           o_pop,
   output logic [CNT_W-1:0]               o_zero_tgt_cnt,
   output logic [CNT_W-1:0]               o_deliv_cnt,
   output logic                           o_proto_err
);
   localparam int PW = $clog2(NUM_PORTS);
   localparam int NW = PW + 1;

   logic [PW-1:0]        r_rr_ptr     [NUM_PORTS];
   logic [NUM_PORTS-1:0] r_served     [NUM_PORTS];
   logic [CNT_W-1:0]     r_zero_cnt;
   logic [CNT_W-1:0]     r_deliv_cnt;
   logic                 r_proto_err;

   logic [NUM_PORTS-1:0] w_target     [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_rem        [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_out_gnt    [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_in_gnt     [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_new_served [NUM_PORTS];
   logic [PW-1:0]        w_next_ptr   [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_pop;
   logic [NUM_PORTS-1:0] w_zero;
   logic [NUM_PORTS-1:0] w_withdraw;
   logic [NUM_PORTS-1:0] w_out_valid;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [NW-1:0]    b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W + 1 - NW){1'b0}}, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   // Reset masks all requests so every output collapses to idle at once.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_target[i] = i_head_target[i*NUM_PORTS +: NUM_PORTS];
         w_rem[i]    = (i_head_valid[i] && !rst) ? (w_target[i] & ~r_served[i]) : '0;
      end
   end

   // Scan farthest-first so the candidate nearest to rr_ptr is the one kept.
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         w_out_gnt[o]  = '0;
         w_next_ptr[o] = r_rr_ptr[o];
         if (i_out_ready[o]) begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
               if (w_rem[r_rr_ptr[o] + PW'(k)][o]) begin
                  w_out_gnt[o]  = NUM_PORTS'(1) << (r_rr_ptr[o] + PW'(k));
                  w_next_ptr[o] = r_rr_ptr[o] + PW'(k + 1);
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_in_gnt[i] = '0;
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            w_in_gnt[i][o] = w_out_gnt[o][i];
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_new_served[i] = r_served[i] | w_in_gnt[i];
         w_zero[i]       = i_head_valid[i] && !rst && (w_target[i] == '0);
         w_pop[i]        = (i_head_valid[i] && !rst && (w_new_served[i] == w_target[i]))
                           || w_zero[i];
         w_withdraw[i]   = !i_head_valid[i] && (r_served[i] != '0);
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         w_out_valid[o] = |w_out_gnt[o];
      end
   end

   always_comb begin
      o_grant = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         o_grant[o*NUM_PORTS +: NUM_PORTS] = w_out_gnt[o];
      end
   end

   assign o_out_valid    = w_out_valid;
   assign o_pop          = w_pop;
   assign o_zero_tgt_cnt = r_zero_cnt;
   assign o_deliv_cnt    = r_deliv_cnt;
   assign o_proto_err    = r_proto_err;

   // A withdrawn head forgets its progress; the replacement starts from scratch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NUM_PORTS; n++) begin
            r_rr_ptr[n] <= '0;
            r_served[n] <= '0;
         end
         r_zero_cnt  <= '0;
         r_deliv_cnt <= '0;
         r_proto_err <= 1'b0;
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            r_rr_ptr[o] <= w_next_ptr[o];
         end
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!i_head_valid[i] || w_pop[i]) begin
               r_served[i] <= '0;
            end else begin
               r_served[i] <= w_new_served[i];
            end
         end
         r_zero_cnt  <= sat_add(r_zero_cnt, NW'($countones(w_zero)));
         r_deliv_cnt <= sat_add(r_deliv_cnt, NW'($countones(w_out_valid)));
         if (|w_withdraw) begin
            r_proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_switch_sched.sv
// Bench for switch_sched: directed scenarios with hand-derived values, then
// randomized traffic compared against a behavioural round-robin model.
module tb_switch_sched;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  headValid;
   logic [15:0] headTarget;
   logic [3:0]  outReady;
   logic [15:0] grant;
   logic [3:0]  outValid;
   logic [3:0]  pop;
   logic [15:0] zeroTgtCnt;
   logic [15:0] delivCnt;
   logic        protoErr;
   int          nCompared = 0;
   int          nMismatched = 0;

   always #5 clk = ~clk;

   switch_sched #(.NUM_PORTS(4), .CNT_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_head_valid   (headValid),
      .i_head_target  (headTarget),
      .i_out_ready    (outReady),
      .o_grant        (grant),
      .o_out_valid    (outValid),
      .o_pop          (pop),
      .o_zero_tgt_cnt (zeroTgtCnt),
      .o_deliv_cnt    (delivCnt),
      .o_proto_err    (protoErr)
   );

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; headValid = '0; headTarget = '0; outReady = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; headValid = 4'hF; headTarget = 16'h8421; outReady = 4'hF;
      #1;
      nCompared++; if (grant !== 16'h0) begin nMismatched++; $display("[TB] FAIL reset_grant: got %h expected 0000", grant); end
      nCompared++; if (outValid !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0000", outValid); end
      nCompared++; if (pop !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_pop: got %b expected 0000", pop); end
      nCompared++; if (zeroTgtCnt !== 16'h0) begin nMismatched++; $display("[TB] FAIL reset_zero_cnt: got %0d expected 0", zeroTgtCnt); end
      nCompared++; if (delivCnt !== 16'h0) begin nMismatched++; $display("[TB] FAIL reset_deliv_cnt: got %0d expected 0", delivCnt); end
      nCompared++; if (protoErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_proto_err: got %b expected 0", protoErr); end
      @(negedge clk);
      headValid = '0; rst = 1'b0;
   endtask

   task automatic test_unicast();
      apply_reset();
      headValid = 4'b0001; headTarget = 16'h0004; outReady = 4'hF;
      #1;
      nCompared++; if (grant !== 16'h0100) begin nMismatched++; $display("[TB] FAIL unicast_grant: got %h expected 0100", grant); end
      nCompared++; if (outValid !== 4'b0100) begin nMismatched++; $display("[TB] FAIL unicast_out_valid: got %b expected 0100", outValid); end
      nCompared++; if (pop !== 4'b0001) begin nMismatched++; $display("[TB] FAIL unicast_pop: got %b expected 0001", pop); end
      @(negedge clk);
      headValid = '0;
      #1;
      nCompared++; if (delivCnt !== 16'd1) begin nMismatched++; $display("[TB] FAIL unicast_deliv_cnt: got %0d expected 1", delivCnt); end
   endtask

   task automatic test_contention();
      logic [3:0] expSel;
      apply_reset();
      headValid = 4'hF; headTarget = 16'h2222; outReady = 4'hF;
      for (int k = 0; k < 8; k++) begin
         expSel = 4'b0001 << (k % 4);
         #1;
         nCompared++; if (grant !== {8'h00, expSel, 4'h0}) begin nMismatched++; $display("[TB] FAIL contention_grant[%0d]: got %h expected %h", k, grant, {8'h00, expSel, 4'h0}); end
         nCompared++; if (pop !== expSel) begin nMismatched++; $display("[TB] FAIL contention_pop[%0d]: got %b expected %b", k, pop, expSel); end
         @(negedge clk);
      end
      headValid = '0;
      #1;
      nCompared++; if (delivCnt !== 16'd8) begin nMismatched++; $display("[TB] FAIL contention_deliv_cnt: got %0d expected 8", delivCnt); end
   endtask

   task automatic test_multicast_backpressure();
      apply_reset();
      headValid = 4'b0001; headTarget = 16'h000A; outReady = 4'b0111;
      #1;
      nCompared++; if (grant !== 16'h0010) begin nMismatched++; $display("[TB] FAIL mcast_c0_grant: got %h expected 0010", grant); end
      nCompared++; if (pop !== 4'b0000) begin nMismatched++; $display("[TB] FAIL mcast_c0_pop: got %b expected 0000", pop); end
      @(negedge clk);
      #1;
      nCompared++; if (grant !== 16'h0000) begin nMismatched++; $display("[TB] FAIL mcast_c1_grant: got %h expected 0000", grant); end
      nCompared++; if (pop !== 4'b0000) begin nMismatched++; $display("[TB] FAIL mcast_c1_pop: got %b expected 0000", pop); end
      @(negedge clk);
      outReady = 4'hF;
      #1;
      nCompared++; if (grant !== 16'h1000) begin nMismatched++; $display("[TB] FAIL mcast_c2_grant: got %h expected 1000", grant); end
      nCompared++; if (outValid !== 4'b1000) begin nMismatched++; $display("[TB] FAIL mcast_c2_out_valid: got %b expected 1000", outValid); end
      nCompared++; if (pop !== 4'b0001) begin nMismatched++; $display("[TB] FAIL mcast_c2_pop: got %b expected 0001", pop); end
      @(negedge clk);
      headValid = '0;
      #1;
      nCompared++; if (delivCnt !== 16'd2) begin nMismatched++; $display("[TB] FAIL mcast_deliv_cnt: got %0d expected 2", delivCnt); end
      nCompared++; if (protoErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL mcast_proto_err: got %b expected 0", protoErr); end
   endtask

   task automatic test_zero_target();
      apply_reset();
      headValid = 4'b0100; headTarget = 16'h0000; outReady = 4'hF;
      #1;
      nCompared++; if (pop !== 4'b0100) begin nMismatched++; $display("[TB] FAIL zero_pop: got %b expected 0100", pop); end
      nCompared++; if (grant !== 16'h0000) begin nMismatched++; $display("[TB] FAIL zero_grant: got %h expected 0000", grant); end
      @(negedge clk);
      headValid = '0;
      #1;
      nCompared++; if (zeroTgtCnt !== 16'd1) begin nMismatched++; $display("[TB] FAIL zero_cnt_1: got %0d expected 1", zeroTgtCnt); end
      headValid = 4'hF;
      #1;
      nCompared++; if (pop !== 4'hF) begin nMismatched++; $display("[TB] FAIL zero_pop_all: got %b expected 1111", pop); end
      @(negedge clk);
      headValid = '0;
      #1;
      nCompared++; if (zeroTgtCnt !== 16'd5) begin nMismatched++; $display("[TB] FAIL zero_cnt_5: got %0d expected 5", zeroTgtCnt); end
      nCompared++; if (delivCnt !== 16'd0) begin nMismatched++; $display("[TB] FAIL zero_deliv_cnt: got %0d expected 0", delivCnt); end
   endtask

   task automatic test_reset_mid_multicast();
      apply_reset();
      headValid = 4'b0010; headTarget = 16'h00F0; outReady = 4'b0011;
      #1;
      nCompared++; if (grant !== 16'h0022) begin nMismatched++; $display("[TB] FAIL rstmc_c0_grant: got %h expected 0022", grant); end
      nCompared++; if (pop !== 4'b0000) begin nMismatched++; $display("[TB] FAIL rstmc_c0_pop: got %b expected 0000", pop); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      nCompared++; if (grant !== 16'h0000) begin nMismatched++; $display("[TB] FAIL rstmc_rst_grant: got %h expected 0000", grant); end
      nCompared++; if (outValid !== 4'b0000) begin nMismatched++; $display("[TB] FAIL rstmc_rst_out_valid: got %b expected 0000", outValid); end
      nCompared++; if (pop !== 4'b0000) begin nMismatched++; $display("[TB] FAIL rstmc_rst_pop: got %b expected 0000", pop); end
      @(negedge clk);
      rst = 1'b0; outReady = 4'hF;
      #1;
      nCompared++; if (grant !== 16'h2222) begin nMismatched++; $display("[TB] FAIL rstmc_after_grant: got %h expected 2222", grant); end
      nCompared++; if (pop !== 4'b0010) begin nMismatched++; $display("[TB] FAIL rstmc_after_pop: got %b expected 0010", pop); end
      @(negedge clk);
      headValid = '0;
      #1;
      nCompared++; if (delivCnt !== 16'd4) begin nMismatched++; $display("[TB] FAIL rstmc_deliv_cnt: got %0d expected 4", delivCnt); end
   endtask

   task automatic test_proto_err();
      apply_reset();
      headValid = 4'b1000; headTarget = 16'h3000; outReady = 4'b0001;
      #1;
      nCompared++; if (grant !== 16'h0008) begin nMismatched++; $display("[TB] FAIL proto_grant: got %h expected 0008", grant); end
      nCompared++; if (pop !== 4'b0000) begin nMismatched++; $display("[TB] FAIL proto_pop: got %b expected 0000", pop); end
      @(negedge clk);
      headValid = '0;
      #1;
      nCompared++; if (protoErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL proto_err_early: got %b expected 0", protoErr); end
      @(negedge clk);
      #1;
      nCompared++; if (protoErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL proto_err_set: got %b expected 1", protoErr); end
      headValid = 4'b0001; headTarget = 16'h0001; outReady = 4'hF;
      repeat (3) @(negedge clk);
      #1;
      nCompared++; if (protoErr !== 1'b1) begin nMismatched++; $display("[TB] FAIL proto_err_sticky: got %b expected 1", protoErr); end
      apply_reset();
      #1;
      nCompared++; if (protoErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL proto_err_cleared: got %b expected 0", protoErr); end
   endtask

   task automatic test_saturation();
      apply_reset();
      headValid = 4'hF; headTarget = 16'h0000; outReady = 4'hF;
      repeat (16383) @(negedge clk);
      #1;
      nCompared++; if (zeroTgtCnt !== 16'hFFFC) begin nMismatched++; $display("[TB] FAIL sat_zero_pre: got %h expected fffc", zeroTgtCnt); end
      @(negedge clk);
      #1;
      nCompared++; if (zeroTgtCnt !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL sat_zero_hit: got %h expected ffff", zeroTgtCnt); end
      @(negedge clk);
      headTarget = 16'h8421;
      #1;
      nCompared++; if (zeroTgtCnt !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL sat_zero_hold: got %h expected ffff", zeroTgtCnt); end
      nCompared++; if (grant !== 16'h8421) begin nMismatched++; $display("[TB] FAIL sat_loop_grant: got %h expected 8421", grant); end
      nCompared++; if (pop !== 4'hF) begin nMismatched++; $display("[TB] FAIL sat_loop_pop: got %b expected 1111", pop); end
      repeat (16383) @(negedge clk);
      #1;
      nCompared++; if (delivCnt !== 16'hFFFC) begin nMismatched++; $display("[TB] FAIL sat_deliv_pre: got %h expected fffc", delivCnt); end
      @(negedge clk);
      #1;
      nCompared++; if (delivCnt !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL sat_deliv_hit: got %h expected ffff", delivCnt); end
      @(negedge clk);
      #1;
      nCompared++; if (delivCnt !== 16'hFFFF) begin nMismatched++; $display("[TB] FAIL sat_deliv_hold: got %h expected ffff", delivCnt); end
   endtask

   // Model: each FIFO is a current head (valid + mask) plus the set of outputs
   // already delivered; each output remembers which input it favours next.
   task automatic test_random();
      int          mRr[4];
      int          mServed[4];
      int          got[4];
      int          mZero;
      int          mDeliv;
      int          in;
      logic [3:0]  tgt[4];
      logic [15:0] expGrant;
      logic [3:0]  expValid;
      logic [3:0]  expPop;
      apply_reset();
      mZero = 0; mDeliv = 0;
      for (int i = 0; i < 4; i++) begin
         mRr[i] = 0; mServed[i] = 0;
         headValid[i] = ($urandom_range(0, 3) != 0);
         tgt[i] = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      for (int cyc = 0; cyc < 500; cyc++) begin
         outReady = 4'($urandom_range(0, 15));
         headTarget = {tgt[3], tgt[2], tgt[1], tgt[0]};
         #1;
         expGrant = '0; expValid = '0; expPop = '0;
         for (int i = 0; i < 4; i++) got[i] = 0;
         for (int o = 0; o < 4; o++) begin
            if (outReady[o]) begin
               for (int k = 0; k < 4; k++) begin
                  in = (mRr[o] + k) % 4;
                  if (headValid[in] && tgt[in][o] && (((mServed[in] >> o) & 1) == 0)) begin
                     expGrant[4*o + in] = 1'b1;
                     expValid[o] = 1'b1;
                     got[in] = got[in] | (1 << o);
                     mRr[o] = (in + 1) % 4;
                     break;
                  end
               end
            end
         end
         for (int i = 0; i < 4; i++) begin
            expPop[i] = headValid[i] && ((mServed[i] | got[i]) == int'(tgt[i]));
         end
         nCompared++; if (grant !== expGrant) begin nMismatched++; $display("[TB] FAIL rand_grant[%0d]: got %h expected %h", cyc, grant, expGrant); end
         nCompared++; if (outValid !== expValid) begin nMismatched++; $display("[TB] FAIL rand_out_valid[%0d]: got %b expected %b", cyc, outValid, expValid); end
         nCompared++; if (pop !== expPop) begin nMismatched++; $display("[TB] FAIL rand_pop[%0d]: got %b expected %b", cyc, pop, expPop); end
         nCompared++; if (zeroTgtCnt !== 16'(mZero)) begin nMismatched++; $display("[TB] FAIL rand_zero_cnt[%0d]: got %0d expected %0d", cyc, zeroTgtCnt, mZero); end
         nCompared++; if (delivCnt !== 16'(mDeliv)) begin nMismatched++; $display("[TB] FAIL rand_deliv_cnt[%0d]: got %0d expected %0d", cyc, delivCnt, mDeliv); end
         nCompared++; if (protoErr !== 1'b0) begin nMismatched++; $display("[TB] FAIL rand_proto_err[%0d]: got %b expected 0", cyc, protoErr); end
         for (int i = 0; i < 4; i++) begin
            if (headValid[i] && tgt[i] == 4'h0) mZero++;
            if (!headValid[i] || expPop[i]) mServed[i] = 0;
            else mServed[i] = mServed[i] | got[i];
         end
         for (int o = 0; o < 4; o++) if (expValid[o]) mDeliv++;
         if (mZero > 65535) mZero = 65535;
         if (mDeliv > 65535) mDeliv = 65535;
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (expPop[i] || !headValid[i]) begin
               headValid[i] = ($urandom_range(0, 3) != 0);
               tgt[i] = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_unicast();
      test_contention();
      test_multicast_backpressure();
      test_zero_target();
      test_reset_mid_multicast();
      test_proto_err();
      test_random();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/switch_sched.md
# switch_sched

Output scheduler for the 4-port switch. Each cycle it looks at the head packet of every input-port FIFO and its target mask, and gives each output port to at most one input using per-output round-robin. Multicast heads are delivered one output at a time or several in parallel, and are popped only after every targeted output has been served. It carries only control: grant selects drive the switch's output muxes, and pop strobes drive the input FIFO read enables.

## Interface
Parameters:
- NUM_PORTS, 4, number of input and output ports. Only 4 is supported.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- head_valid  in  4  bit i set when input FIFO i is non-empty.
- head_target  in  16  target mask of input i's head packet, in bits [4i+3:4i]; bit o means "deliver to output o".
- out_ready  in  4  output o can accept a beat this cycle.
- grant  out  16  bits [4o+3:4o] are a one-hot input select for output o; all zero means idle.
- out_valid  out  4  output o carries a beat this cycle; equals the OR of output o's grant bits.
- pop  out  4  pulse that pops input FIFO i this cycle.
- zero_tgt_cnt  out  CNT_W  number of heads discarded because their target mask was zero; saturates.
- deliv_cnt  out  CNT_W  total output beats granted; saturates.
- proto_err  out  1  sticky flag: a head was withdrawn while partially served.

## Operation
- State:
  - rr_ptr[o] (2 bits per output): the highest-priority input for output o.
  - served[i] (4 bits per input): outputs already delivered for the current head of input i.
  - the counters and proto_err.
- Remaining request: rem[i] = head_valid[i] ? (head_target[i] & ~served[i]) : 0.
- Per-output arbitration: output o considers only inputs with rem[i][o]=1, and only when out_ready[o]=1.
  - It grants the first such input found searching i = rr_ptr[o], rr_ptr[o]+1, … modulo 4.
  - After granting input g, rr_ptr[o] becomes (g+1) mod 4; with no grant, rr_ptr[o] is unchanged.
- Outputs arbitrate independently. One input may be granted by several outputs in the same cycle (parallel multicast). An output never grants more than one input.
- Loopback is legal: input i may target output i.
- Head completion: let new_served[i] = served[i] | {bits o where output o granted i}.
  - If head_valid[i] and new_served[i] == head_target[i], then pop[i]=1 and served[i] is cleared to 0.
  - Otherwise served[i] is updated to new_served[i].
- Zero-target head: if head_valid[i] and head_target[i]==0, then pop[i]=1 with no grant, and zero_tgt_cnt increments.
  - At most 4 such heads can occur in one cycle; the counter adds that count.
- deliv_cnt adds popcount(out_valid) each cycle. Both counters saturate at 2^CNT_W−1.
- Protocol requirement: the head packet and head_target[i] stay stable from first service until pop.
  - If head_valid[i] falls while served[i]≠0: proto_err is set (sticky until reset) and served[i] is cleared.
- Reset:
  - rst asserted forces grant, out_valid and pop to 0 combinationally.
  - rr_ptr, served, both counters and proto_err reset to 0.
  - Reset in the middle of a multicast discards served[]; after reset the head is delivered again to its full target mask.

## Timing
- grant, out_valid and pop are combinational from the inputs plus registered state, so request-to-grant latency is 0 cycles.
- pop is asserted in the same cycle as the head's final grant. The FIFO presents its next head in the following cycle.
- Throughput: each output sustains 1 beat per cycle. A unicast head can be popped every cycle from each input.
- served, rr_ptr, the counters and proto_err update on the clk edge that ends the decision cycle.
  - Counters are visible one cycle after the event.
- No combinational path from out_ready[o] to grant of any other output o'≠o.
- out_ready low: output o grants nothing and keeps its rr_ptr. The remaining targets of a multicast head wait; other inputs are not blocked on other outputs.
- Simultaneous final grant on one output and a new request arriving on another input for that output: the arbitration order uses the rr_ptr value from before the edge.

## Test plan
- Unicast: head_valid=0001, in0 target=0100, out_ready=1111 → same cycle grant[11:8]=0001, out_valid=0100, pop=0001; deliv_cnt=1 one cycle later.
- Contention: all four inputs continuously target 0010, out_ready=1111, rr_ptr[1]=0 → output 1 grants inputs 0,1,2,3,0,… on consecutive cycles; pop rotates 0001, 0010, 0100, 1000.
- Multicast with backpressure: in0 target=1010, out_ready[3]=0 for cycles 0–1 then 1.
  - Cycle 0: output 1 grants in0, pop=0, served[0]=0010.
  - Cycle 2: output 3 grants in0 and pop[0]=1.
- Zero target: in2 head_valid=1, target=0000 → pop=0100, grant=0; zero_tgt_cnt goes 0→1.
- Reset mid-multicast: in1 target=1111, out_ready=0011.
  - Cycle 0: outputs 0 and 1 grant in1.
  - Assert rst during cycle 1: outputs are 0 and served is cleared.
  - After release with out_ready=1111: all four outputs grant in1 in one cycle and pop[1]=1.
- Protocol error: in3 partially served (served[3]=0001), head_valid[3] drops → proto_err=1 the next cycle and stays 1 until rst.
